// File: rtl/alu_controller_pkg.sv
// Shared definitions for the ALU controller: datapath width, ALU op codes and FSM encoding.
package alu_controller_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 4;

  typedef logic [OP_W-1:0] op_t;

  // ALU select codes; the controller forwards them untouched, the ALU gives them meaning.
  localparam op_t OP_ADD  = 4'b0000;
  localparam op_t OP_SUB  = 4'b0001;
  localparam op_t OP_AND  = 4'b0010;
  localparam op_t OP_OR   = 4'b0011;
  localparam op_t OP_XOR  = 4'b0100;
  localparam op_t OP_NOT  = 4'b0101;
  localparam op_t OP_SHL  = 4'b0110;
  localparam op_t OP_SHR  = 4'b0111;
  localparam op_t OP_INC  = 4'b1000;
  localparam op_t OP_DEC  = 4'b1001;
  localparam op_t OP_MUL  = 4'b1010;
  localparam op_t OP_DIV  = 4'b1011;
  localparam op_t OP_MOD  = 4'b1100;
  localparam op_t OP_PASS = 4'b1101;
  localparam op_t OP_LT   = 4'b1110;
  localparam op_t OP_EQ   = 4'b1111;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'b00;
  localparam state_t StExec = 2'b01;
  localparam state_t StResp = 2'b10;

  function automatic logic is_zero(input logic [DATA_W-1:0] value);
    return value == '0;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, two read ports latched on an enable,
// and one combinational debug read port.
module alu_regfile #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NREGS  = 4,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [NREGS-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]            rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]            rdata_b_q, rdata_b_d;

  // Next-state for storage and the latched operand ports.
  always_comb begin
    mem_d     = mem_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
    // Reads see the pre-write contents, so rd==ra/rb picks up the old value.
    if (rd_en_i) begin
      rdata_a_d = mem_q[raddr_a_i];
      rdata_b_d = mem_q[raddr_b_i];
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Output ports.
  always_comb begin
    rdata_a_o  = rdata_a_q;
    rdata_b_o  = rdata_b_q;
    dbg_data_o = mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_controller.sv
// Three-state controller sequencing one ALU operation per request:
// IDLE accepts and latches operands, EXEC drives the ALU and writes back, RESP holds the result.
module alu_controller #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NREGS  = 4,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [AW-1:0]     req_rd,
  input  logic [AW-1:0]     req_ra,
  input  logic [AW-1:0]     req_rb,
  input  logic              req_imm_en,
  input  logic [DATA_W-1:0] req_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic [AW-1:0]     rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data
);

  import alu_controller_pkg::*;

  state_t            state_q, state_d;
  logic              accept;
  logic              rf_we;
  logic [AW-1:0]     rd_q, rd_d;
  op_t               sel_q, sel_d;
  logic              imm_en_q, imm_en_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [DATA_W-1:0] rf_a, rf_b;

  // Handshake decode and write-back enable.
  always_comb begin
    req_ready = (state_q == StIdle);
    accept    = req_valid & req_ready;
    rf_we     = (state_q == StExec);
  end

  // FSM and datapath next-state; requests outside IDLE never reach here because accept is 0.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    sel_d       = sel_q;
    imm_en_d    = imm_en_q;
    imm_d       = imm_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rd_d     = req_rd;
          sel_d    = req_op;
          imm_en_d = req_imm_en;
          imm_d    = req_imm;
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = alu_out;
        rsp_carry_d = alu_carry;
        rsp_zero_d  = is_zero(alu_out);
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state, cleared asynchronously so a reset mid-operation aborts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_q        <= '0;
      sel_q       <= '0;
      imm_en_q    <= 1'b0;
      imm_q       <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      sel_q       <= sel_d;
      imm_en_q    <= imm_en_d;
      imm_q       <= imm_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (alu_out),
    .rd_en_i    (accept),
    .raddr_a_i  (req_ra),
    .raddr_b_i  (req_rb),
    .rdata_a_o  (rf_a),
    .rdata_b_o  (rf_b),
    .dbg_addr_i (rf_rd_addr),
    .dbg_data_o (rf_rd_data)
  );

  // Outputs; ALU operands come straight from latched registers so they hold outside EXEC.
  always_comb begin
    rsp_valid = (state_q == StResp);
    rsp_data  = rsp_data_q;
    rsp_carry = rsp_carry_q;
    rsp_zero  = rsp_zero_q;
    alu_a     = rf_a;
    alu_b     = imm_en_q ? imm_q : rf_b;
    alu_sel   = sel_q;
  end

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller with a small behavioural ALU on the alu_* ports.
module tb_alu_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = '0;
  logic [1:0] req_rd = '0, req_ra = '0, req_rb = '0;
  logic       req_imm_en = 1'b0;
  logic [3:0] req_imm = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_data;
  logic       rsp_carry, rsp_zero;
  logic [3:0] alu_a, alu_b, alu_sel, alu_out;
  logic       alu_carry;
  logic [1:0] rf_rd_addr = '0;
  logic [3:0] rf_rd_data;
  logic [4:0] alu_w;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    logic       imm_en;
    logic [3:0] imm;
    logic [3:0] data;
    logic       carry, zero;
  } vec_t;

  vec_t vecs[11];

  alu_controller #(.DATA_W(4), .NREGS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_ra     (req_ra),
    .req_rb     (req_rb),
    .req_imm_en (req_imm_en),
    .req_imm    (req_imm),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: carry is the 5th sum bit for ADD and the borrow for SUB.
  always_comb begin
    alu_w     = '0;
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      4'h0: begin
        alu_w     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = alu_w[3:0];
        alu_carry = alu_w[4];
      end
      4'h1: begin
        alu_w     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out   = alu_w[3:0];
        alu_carry = alu_w[4];
      end
      4'h2: alu_out = alu_a & alu_b;
      4'h4: alu_out = alu_a ^ alu_b;
      4'hE: alu_out = (alu_a < alu_b) ? 4'h1 : 4'h0;
      4'hF: alu_out = (alu_a == alu_b) ? 4'h1 : 4'h0;
      default: alu_out = alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] idx, input logic [3:0] exp);
    rf_rd_addr = idx;
    #1;
    chk($sformatf("%s_r%0d", name, idx), rf_rd_data, exp);
  endtask

  // Issue one request, walk it through EXEC and RESP with rsp_ready=1, check the result.
  task automatic do_op(input vec_t v, input string tag, output int unsigned rsp_cyc);
    chk({tag, "_ready"}, req_ready, 1);
    req_op     = v.op;
    req_rd     = v.rd;
    req_ra     = v.ra;
    req_rb     = v.rb;
    req_imm_en = v.imm_en;
    req_imm    = v.imm;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, "_exec_valid"}, rsp_valid, 0);
    chk({tag, "_sel"}, alu_sel, v.op);
    step();
    rsp_cyc = cyc;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, v.data);
    chk({tag, "_carry"}, rsp_carry, v.carry);
    chk({tag, "_zero"}, rsp_zero, v.zero);
    chk_reg(tag, v.rd, v.data);
    step();
  endtask

  initial begin
    int unsigned rc, prev_rc;
    vec_t v;

    //        op    rd    ra    rb    imm_en imm   data  carry zero
    vecs[0]  = '{4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0};
    vecs[1]  = '{4'h0, 2'd1, 2'd0, 2'd0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0};
    vecs[2]  = '{4'h0, 2'd2, 2'd1, 2'd0, 1'b1, 4'h1, 4'h0, 1'b1, 1'b1};
    vecs[3]  = '{4'h0, 2'd3, 2'd1, 2'd1, 1'b0, 4'h0, 4'hE, 1'b1, 1'b0};
    vecs[4]  = '{4'h1, 2'd2, 2'd3, 2'd1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0};
    vecs[5]  = '{4'h2, 2'd0, 2'd3, 2'd0, 1'b1, 4'h6, 4'h6, 1'b0, 1'b0};
    vecs[6]  = '{4'h4, 2'd3, 2'd3, 2'd0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0};
    vecs[7]  = '{4'hE, 2'd1, 2'd0, 2'd3, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0};
    vecs[8]  = '{4'hF, 2'd2, 2'd1, 2'd0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0};
    vecs[9]  = '{4'hF, 2'd0, 2'd0, 2'd3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[10] = '{4'hB, 2'd3, 2'd2, 2'd0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1};

    // Reset state.
    #3;
    chk("rst_low_valid", rsp_valid, 0);
    #9;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    for (int i = 0; i < 4; i++) chk_reg("rst", 2'(i), 4'h0);
    step();
    chk("rst_ready_cyc1", req_ready, 1);

    // Back-to-back table: each response must arrive exactly 3 cycles after the previous one.
    prev_rc = 0;
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i), rc);
      if (i > 0) chk($sformatf("vec%0d_spacing", i), rc - prev_rc, 3);
      prev_rc = rc;
    end
    chk_reg("table_end", 2'd0, 4'h0);
    chk_reg("table_end", 2'd1, 4'h1);
    chk_reg("table_end", 2'd2, 4'h1);
    chk_reg("table_end", 2'd3, 4'h0);

    // Backpressure: r1=1, ADD imm 2 into r1 -> 3, held while a stray request is presented.
    rsp_ready  = 1'b0;
    req_op     = 4'h0;
    req_rd     = 2'd1;
    req_ra     = 2'd1;
    req_imm_en = 1'b1;
    req_imm    = 4'h2;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    req_op    = 4'h4;
    req_rd    = 2'd0;
    req_imm   = 4'h7;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), rsp_valid, 1);
      chk($sformatf("bp%0d_data", i), rsp_data, 4'h3);
      chk($sformatf("bp%0d_ready", i), req_ready, 0);
      step();
    end
    req_valid = 1'b0;
    chk("bp_sel_held", alu_sel, 4'h0);
    rsp_ready = 1'b1;
    step();
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_valid", rsp_valid, 0);
    chk_reg("bp", 2'd0, 4'h0);
    chk_reg("bp", 2'd1, 4'h3);

    // Abort: reset pulse during EXEC of ADD r1(3)+5 -> r2.
    req_op     = 4'h0;
    req_rd     = 2'd2;
    req_ra     = 2'd1;
    req_imm_en = 1'b1;
    req_imm    = 4'h5;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    chk("abort_in_exec", req_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async_ready", req_ready, 1);
    chk("abort_async_data", rsp_data, 0);
    chk("abort_async_alu_a", alu_a, 0);
    chk("abort_async_alu_b", alu_b, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) chk_reg("abort", 2'(i), 4'h0);

    // Fresh operation after the abort.
    v = '{4'h0, 2'd3, 2'd0, 2'd0, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0};
    do_op(v, "post_abort", rc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
